// File: rtl/pim_req_scheduler.sv
// Request buffer ahead of the DDR3 controller. Requests are reordered to favour
// open-row hits, and a bypass cap bounds how long the oldest request can be skipped.
module pim_req_scheduler #(
  parameter int DEPTH      = 8,
  parameter int MAX_BYPASS = 4,
  parameter int BANK_LSB   = 10,
  parameter int ROW_LSB    = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [31:0]              hit_count,
  output logic [31:0]              issue_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BYPASS + 1);
  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [BW-1:0] MaxBypC  = BW'(MAX_BYPASS);

  logic [31:0]   queue_q [DEPTH];
  logic [31:0]   queue_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          outValid_q, outValid_d;
  logic [31:0]   outAddr_q, outAddr_d;
  logic [BW-1:0] bypassCnt_q, bypassCnt_d;
  logic [7:0]    openValid_q, openValid_d;
  logic [13:0]   openRow_q [8];
  logic [13:0]   openRow_d [8];
  logic [31:0]   hitCount_q, hitCount_d;
  logic [31:0]   issueCount_q, issueCount_d;

  logic [DEPTH-1:0] hitVec;
  logic [IW-1:0]    selIdx;
  logic [31:0]      selAddr;
  logic             selHit;
  logic             load;
  logic             enq;
  logic [CW-1:0]    countAfter;

  function automatic logic [2:0] bankOf(input logic [31:0] a);
    return a[BANK_LSB +: 3];
  endfunction

  function automatic logic [13:0] rowOf(input logic [31:0] a);
    return a[ROW_LSB +: 14];
  endfunction

  assign in_ready    = rst_n && (count_q < DepthC);
  assign out_valid   = outValid_q;
  assign out_addr    = outAddr_q;
  assign queue_count = count_q;
  assign hit_count   = hitCount_q;
  assign issue_count = issueCount_q;

  assign load       = (!outValid_q || out_ready) && (count_q != '0);
  assign enq        = in_valid && in_ready;
  assign countAfter = count_q - {{(CW-1){1'b0}}, load};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hitVec[i] = (CW'(i) < count_q) && openValid_q[bankOf(queue_q[i])] &&
                  (openRow_q[bankOf(queue_q[i])] == rowOf(queue_q[i]));
    end
  end

  // Lowest-index hit wins unless the oldest entry has been skipped too often.
  always_comb begin
    selIdx = '0;
    if (bypassCnt_q != MaxBypC) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (hitVec[i]) selIdx = IW'(i);
      end
    end
    selAddr = queue_q[selIdx];
    selHit  = hitVec[selIdx];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) queue_d[i] = queue_q[i];
    for (int i = 0; i < 8; i++) openRow_d[i] = openRow_q[i];
    openValid_d  = openValid_q;
    outValid_d   = outValid_q;
    outAddr_d    = outAddr_q;
    bypassCnt_d  = bypassCnt_q;
    hitCount_d   = hitCount_q;
    issueCount_d = issueCount_q + {31'd0, outValid_q && out_ready};
    count_d      = countAfter + {{(CW-1){1'b0}}, enq};

    if (outValid_q && out_ready) outValid_d = 1'b0;

    if (load) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= selIdx) queue_d[i] = queue_q[i + 1];
      end
      outValid_d                  = 1'b1;
      outAddr_d                   = selAddr;
      openRow_d[bankOf(selAddr)]  = rowOf(selAddr);
      openValid_d[bankOf(selAddr)] = 1'b1;
      hitCount_d                  = hitCount_q + {31'd0, selHit};
      if (selIdx == '0)
        bypassCnt_d = '0;
      else if (bypassCnt_q != MaxBypC)
        bypassCnt_d = bypassCnt_q + 1'b1;
    end

    // Append lands after the compaction above so age order is kept.
    if (enq) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (countAfter == CW'(i)) queue_d[i] = in_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
      for (int i = 0; i < 8; i++) openRow_q[i] <= '0;
      count_q      <= '0;
      outValid_q   <= 1'b0;
      outAddr_q    <= '0;
      bypassCnt_q  <= '0;
      openValid_q  <= '0;
      hitCount_q   <= '0;
      issueCount_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= queue_d[i];
      for (int i = 0; i < 8; i++) openRow_q[i] <= openRow_d[i];
      count_q      <= count_d;
      outValid_q   <= outValid_d;
      outAddr_q    <= outAddr_d;
      bypassCnt_q  <= bypassCnt_d;
      openValid_q  <= openValid_d;
      hitCount_q   <= hitCount_d;
      issueCount_q <= issueCount_d;
    end
  end

endmodule

// File: tb/tb_pim_req_scheduler.sv
// Directed self-checking bench for pim_req_scheduler: reordering, bypass cap,
// backpressure and reset behaviour with hand-computed expectations.
module tb_pim_req_scheduler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [3:0]  queue_count;
  logic [31:0] hit_count;
  logic [31:0] issue_count;

  int total;
  int bad;
  logic [31:0] got [16];
  int gotN;

  pim_req_scheduler #(
    .DEPTH(8), .MAX_BYPASS(4), .BANK_LSB(10), .ROW_LSB(13)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .queue_count(queue_count), .hit_count(hit_count), .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records each presented address whose handshake completes; bounded in cycles.
  task automatic collect_issues(input int n);
    gotN = 0;
    for (int cyc = 0; cyc < 60 && gotN < n; cyc++) begin
      if (out_valid && out_ready) begin
        got[gotN] = out_addr;
        gotN++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_addr = '0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (queue_count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", queue_count); end
    total++; if (hit_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_hits got=%0d exp=0", hit_count); end
    total++; if (issue_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_issues got=%0d exp=0", issue_count); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    in_addr = 32'h0000_2400; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early got=%b exp=0", out_valid); end
    total++; if (queue_count !== 4'd1) begin bad++; $display("[TB] FAIL single_count got=%0d exp=1", queue_count); end
    tick();
    total++; if (out_valid !== 1'b1 || out_addr !== 32'h0000_2400) begin
      bad++; $display("[TB] FAIL single_present got=%b/%h exp=1/00002400", out_valid, out_addr); end
    tick();
    total++; if (issue_count !== 32'd1) begin bad++; $display("[TB] FAIL single_issues got=%0d exp=1", issue_count); end
    total++; if (hit_count !== 32'd0) begin bad++; $display("[TB] FAIL single_hits got=%0d exp=0", hit_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_row_hit_reorder();
    logic [31:0] exp [3];
    exp[0] = 32'h0000_2000; exp[1] = 32'h0000_2040; exp[2] = 32'h0000_4000;
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 32'h0000_2000; tick();
    in_addr = 32'h0000_4000; tick();
    in_addr = 32'h0000_2040; tick();
    in_valid = 1'b0;
    total++; if (queue_count !== 4'd2 || out_addr !== 32'h0000_2000) begin
      bad++; $display("[TB] FAIL reorder_setup got=%0d/%h exp=2/00002000", queue_count, out_addr); end
    out_ready = 1'b1;
    collect_issues(3);
    total++; if (gotN !== 3) begin bad++; $display("[TB] FAIL reorder_timeout got=%0d exp=3", gotN); end
    for (int i = 0; i < 3; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("[TB] FAIL reorder_order[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    total++; if (hit_count !== 32'd1) begin bad++; $display("[TB] FAIL reorder_hits got=%0d exp=1", hit_count); end
    total++; if (issue_count !== 32'd4) begin bad++; $display("[TB] FAIL reorder_issues got=%0d exp=4", issue_count); end
  endtask

  task automatic test_starvation_cap();
    logic [31:0] seq [8];
    logic [31:0] exp [8];
    // X hits bank0 row2, M misses (row3), H1..H6 hit row2.
    seq[0] = 32'h0000_4000; seq[1] = 32'h0000_6000;
    for (int k = 1; k <= 6; k++) seq[k + 1] = 32'h0000_4000 + 32'(k * 16);
    exp[0] = seq[0]; exp[1] = seq[2]; exp[2] = seq[3]; exp[3] = seq[4];
    exp[4] = seq[5]; exp[5] = seq[1]; exp[6] = seq[6]; exp[7] = seq[7];
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_addr = seq[k];
      tick();
    end
    in_valid = 1'b0;
    total++; if (queue_count !== 4'd7) begin bad++; $display("[TB] FAIL starve_count got=%0d exp=7", queue_count); end
    out_ready = 1'b1;
    collect_issues(8);
    total++; if (gotN !== 8) begin bad++; $display("[TB] FAIL starve_timeout got=%0d exp=8", gotN); end
    for (int i = 0; i < 8; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("[TB] FAIL starve_order[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    total++; if (hit_count !== 32'd7) begin bad++; $display("[TB] FAIL starve_hits got=%0d exp=7", hit_count); end
    total++; if (issue_count !== 32'd12) begin bad++; $display("[TB] FAIL starve_issues got=%0d exp=12", issue_count); end
  endtask

  task automatic test_full_backpressure();
    int accepted;
    accepted = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_addr = 32'h0100_0000 + 32'(k * 64);
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    total++; if (accepted !== 9) begin bad++; $display("[TB] FAIL full_accepted got=%0d exp=9", accepted); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_in_ready got=%b exp=0", in_ready); end
    total++; if (queue_count !== 4'd8) begin bad++; $display("[TB] FAIL full_count got=%0d exp=8", queue_count); end
    for (int c = 0; c < 20; c++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_addr !== 32'h0100_0000 || queue_count !== 4'd8) begin
        bad++; $display("[TB] FAIL stall_hold[%0d] got=%b/%h/%0d exp=1/01000000/8", c, out_valid, out_addr, queue_count); end
    end
  endtask

  task automatic test_simultaneous();
    in_addr = 32'h0200_0000; in_valid = 1'b1; out_ready = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL simul_refuse got=%b exp=0", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (queue_count !== 4'd7) begin bad++; $display("[TB] FAIL simul_count got=%0d exp=7", queue_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL simul_ready_next got=%b exp=1", in_ready); end
    collect_issues(8);
    total++; if (gotN !== 8) begin bad++; $display("[TB] FAIL drain_timeout got=%0d exp=8", gotN); end
    for (int i = 0; i < 8; i++) begin
      total++; if (got[i] !== 32'h0100_0000 + 32'((i + 1) * 64)) begin
        bad++; $display("[TB] FAIL drain_order[%0d] got=%h exp=%h", i, got[i], 32'h0100_0000 + 32'((i + 1) * 64)); end
    end
    tick(); tick();
    total++; if (out_valid !== 1'b0 || queue_count !== 4'd0) begin
      bad++; $display("[TB] FAIL drain_empty got=%b/%0d exp=0/0", out_valid, queue_count); end
    total++; if (issue_count !== 32'd21) begin bad++; $display("[TB] FAIL drain_issues got=%0d exp=21", issue_count); end
    total++; if (hit_count !== 32'd15) begin bad++; $display("[TB] FAIL drain_hits got=%0d exp=15", hit_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_addr = 32'h0100_0000 + 32'(k * 64);
      tick();
    end
    in_valid = 1'b0;
    total++; if (queue_count !== 4'd5) begin bad++; $display("[TB] FAIL mid_setup got=%0d exp=5", queue_count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || queue_count !== 4'd0) begin
      bad++; $display("[TB] FAIL mid_cleared got=%b/%0d exp=0/0", out_valid, queue_count); end
    total++; if (hit_count !== 32'd0 || issue_count !== 32'd0) begin
      bad++; $display("[TB] FAIL mid_counters got=%0d/%0d exp=0/0", hit_count, issue_count); end
    in_addr = 32'h0100_0000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_addr !== 32'h0100_0000) begin
      bad++; $display("[TB] FAIL mid_present got=%b/%h exp=1/01000000", out_valid, out_addr); end
    tick();
    total++; if (hit_count !== 32'd0) begin bad++; $display("[TB] FAIL mid_open_row_cleared got=%0d exp=0", hit_count); end
    total++; if (issue_count !== 32'd1) begin bad++; $display("[TB] FAIL mid_issues got=%0d exp=1", issue_count); end
  endtask

  initial begin
    total = 0; bad = 0; gotN = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_addr = '0;
    test_reset();
    test_single();
    test_row_hit_reorder();
    test_starvation_cap();
    test_full_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
